// File: rtl/mean_thresh.sv
// Adaptive-threshold binarizer: buffers the raw gray stream in a row ring and compares each
// centre pixel against its 9x9 mean minus OFFSET_C. Build option: MEAN_THRESH_INVERT_EN flips polarity.
module mean_thresh #(
  parameter int          IMAGE_WIDTH = 320,
  parameter int          ROW_W       = 11,
  parameter int          COL_W       = 10,
  parameter int          BUF_ROWS    = 8,
  parameter logic [7:0]  OFFSET_C    = 8'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gray_valid,
  input  logic [7:0]       gray,
  input  logic             mean_valid,
  input  logic [7:0]       mean_in,
  input  logic [ROW_W-1:0] center_row,
  input  logic [COL_W-1:0] center_col,
  output logic             bin_valid,
  output logic [7:0]       bin_out,
  output logic [ROW_W-1:0] bin_row,
  output logic [COL_W-1:0] bin_col,
  output logic             err_overrun
);

  localparam int DATA_W = 8;
  localparam int RB     = $clog2(BUF_ROWS);
  localparam int DEPTH  = BUF_ROWS * IMAGE_WIDTH;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ROW_W-1:0] ROW_MAX  = '1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);

  function automatic logic [ADDR_W-1:0] buf_addr(input logic [RB-1:0]    row_lo,
                                                 input logic [COL_W-1:0] col);
    buf_addr = ADDR_W'(row_lo) * ADDR_W'(IMAGE_WIDTH) + ADDR_W'(col);
  endfunction

  function automatic logic [ROW_W-1:0] row_inc_sat(input logic [ROW_W-1:0] r);
    row_inc_sat = (r == ROW_MAX) ? r : r + ROW_W'(1);
  endfunction

  // A request is stale once its ring slot has been reused, or premature if not yet written.
  function automatic logic is_overrun(input logic [ROW_W-1:0] c_row,
                                      input logic [COL_W-1:0] c_col,
                                      input logic [ROW_W-1:0] w_row,
                                      input logic [COL_W-1:0] w_col);
    logic [ROW_W:0] reach;
    reach      = {1'b0, c_row} + (ROW_W+1)'(BUF_ROWS);
    is_overrun = (reach <= {1'b0, w_row}) || (c_row > w_row) ||
                 ((c_row == w_row) && (c_col >= w_col));
  endfunction

  // Widened to 10 bits so pixel + offset never wraps.
  function automatic logic is_fg(input logic [DATA_W-1:0] pix,
                                 input logic [DATA_W-1:0] mean);
    logic [DATA_W+1:0] lhs;
    lhs = {2'b00, pix} + {2'b00, OFFSET_C};
`ifdef MEAN_THRESH_INVERT_EN
    is_fg = (lhs <= {2'b00, mean});
`else
    is_fg = (lhs > {2'b00, mean});
`endif
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_en   = gray_valid && !rst;
  assign wr_addr = buf_addr(wr_row[RB-1:0], wr_col);
  assign rd_addr = buf_addr(center_row[RB-1:0], center_col);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= gray;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (gray_valid) begin
      if (wr_col == COL_LAST) begin
        wr_col <= '0;
        wr_row <= row_inc_sat(wr_row);
      end else begin
        wr_col <= wr_col + COL_W'(1);
      end
    end
  end

  // Stage p1: RAM read (old data on same-cycle collision) and overrun check
  logic              vld_p1;
  logic              ovr_p1;
  logic [DATA_W-1:0] pix_p1;
  logic [DATA_W-1:0] mean_p1;
  logic [ROW_W-1:0]  row_p1;
  logic [COL_W-1:0]  col_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= mean_valid;
  end

  always_ff @(posedge clk) begin
    if (mean_valid) begin
      pix_p1  <= mem[rd_addr];
      mean_p1 <= mean_in;
      row_p1  <= center_row;
      col_p1  <= center_col;
      ovr_p1  <= is_overrun(center_row, center_col, wr_row, wr_col);
    end
  end

  // Stage p2: threshold compare and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_valid   <= 1'b0;
      bin_out     <= '0;
      bin_row     <= '0;
      bin_col     <= '0;
      err_overrun <= 1'b0;
    end else begin
      bin_valid <= vld_p1;
      if (vld_p1) begin
        bin_out <= is_fg(pix_p1, mean_p1) ? 8'd255 : 8'd0;
        bin_row <= row_p1;
        bin_col <= col_p1;
        if (ovr_p1) err_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mean_thresh.sv
// Randomized scoreboard bench for mean_thresh; the reference keeps the full pixel history per
// (row, col) and resolves each request to the most recent write sharing its ring slot.
module tb_mean_thresh;
  localparam int W      = 320;
  localparam int ROW_W  = 11;
  localparam int COL_W  = 10;
  localparam int BROWS  = 8;
  localparam int OFFS   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             gray_valid;
  logic [7:0]       gray;
  logic             mean_valid;
  logic [7:0]       mean_in;
  logic [ROW_W-1:0] center_row;
  logic [COL_W-1:0] center_col;
  logic             bin_valid;
  logic [7:0]       bin_out;
  logic [ROW_W-1:0] bin_row;
  logic [COL_W-1:0] bin_col;
  logic             err_overrun;

  mean_thresh dut (
    .clk(clk), .rst(rst),
    .gray_valid(gray_valid), .gray(gray),
    .mean_valid(mean_valid), .mean_in(mean_in),
    .center_row(center_row), .center_col(center_col),
    .bin_valid(bin_valid), .bin_out(bin_out),
    .bin_row(bin_row), .bin_col(bin_col),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    int bin;
    bit known;
    bit err;
    int t;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] hist[int];
  int         wr_row_m, wr_col_m;
  bit         sticky_m;
  int         cyc_cnt = 0;
  int         tests = 0;
  int         fails = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  // Pixel currently held in the ring slot addressed by (cr, cc), or -1 if never written.
  function automatic int lookup(input int cr, input int cc);
    for (int r = wr_row_m; r >= 0; r--)
      if ((r % BROWS) == (cr % BROWS) && hist.exists(r * W + cc))
        return int'(hist[r * W + cc]);
    return -1;
  endfunction

  function automatic int pick_mean(input int p);
    int k;
    if (p < 0) return int'($urandom_range(255, 0));
    k = int'($urandom_range(5, 0));
    case (k)
      0: return (p + 5 > 255) ? 255 : p + 5;
      1: return (p + 4 > 255) ? 255 : p + 4;
      2: return p;
      3: return 0;
      4: return 255;
      default: return int'($urandom_range(255, 0));
    endcase
  endfunction

  function automatic int pick_pix();
    case ($urandom_range(7, 0))
      0: return 0;
      1: return 255;
      2: return 90;
      3: return 91;
      default: return int'($urandom_range(255, 0));
    endcase
  endfunction

  task automatic push_expect(input int cr, input int cc, input int m);
    exp_t e;
    int   p;
    bit   ovr, fg;
    ovr = (cr + BROWS <= wr_row_m) || (cr > wr_row_m) ||
          (cr == wr_row_m && cc >= wr_col_m);
    sticky_m = sticky_m | ovr;
    p = lookup(cr, cc);
`ifdef MEAN_THRESH_INVERT_EN
    fg = (p + OFFS <= m);
`else
    fg = (p + OFFS > m);
`endif
    e.row = cr; e.col = cc; e.known = (p >= 0);
    e.bin = fg ? 255 : 0; e.err = sticky_m; e.t = cyc_cnt;
    expq.push_back(e);
  endtask

  task automatic model_write(input int g);
    hist[wr_row_m * W + wr_col_m] = 8'(g);
    if (wr_col_m == W - 1) begin
      wr_col_m = 0;
      if (wr_row_m < (1 << ROW_W) - 1) wr_row_m++;
    end else begin
      wr_col_m++;
    end
  endtask

  task automatic cyc(input bit gv, input int g, input bit mv, input int m,
                     input int cr, input int cc);
    @(negedge clk);
    gray_valid = gv; gray = 8'(g);
    mean_valid = mv; mean_in = 8'(m);
    center_row = ROW_W'(cr); center_col = COL_W'(cc);
    if (mv) push_expect(cr, cc, m);
    if (gv) model_write(g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    gray_valid = 1'b1; gray = 8'hAA;
    mean_valid = 1'b1; mean_in = 8'd0; center_row = '0; center_col = '0;
    expq.delete(); hist.delete();
    wr_row_m = 0; wr_col_m = 0; sticky_m = 1'b0;
    @(negedge clk);
    rst = 1'b0; gray_valid = 1'b0; mean_valid = 1'b0;
    check("rst_bin_valid", int'(bin_valid), 0);
    check("rst_bin_out", int'(bin_out), 0);
    check("rst_bin_row", int'(bin_row), 0);
    check("rst_bin_col", int'(bin_col), 0);
    check("rst_err_overrun", int'(err_overrun), 0);
  endtask

  always @(negedge clk) begin
    if (bin_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check("spurious_bin_valid", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("latency", cyc_cnt - e.t, 2);
        check("bin_row", int'(bin_row), e.row);
        check("bin_col", int'(bin_col), e.col);
        if (e.known) check("bin_out", int'(bin_out), e.bin);
        check("err_overrun", int'(err_overrun), int'(e.err));
      end
    end
  end

  initial begin
    rst = 1'b0; gray_valid = 1'b0; gray = '0; mean_valid = 1'b0; mean_in = '0;
    center_row = '0; center_col = '0;
    wr_row_m = 0; wr_col_m = 0; sticky_m = 1'b0;
    do_reset();

    // Flat image: pixel 100, mean 100
    while (wr_row_m < 3) begin
      bit mv;
      mv = (wr_row_m >= 1) && ($urandom_range(1, 0) == 1);
      cyc(1, 100, mv, 100, wr_row_m - 1, int'($urandom_range(W - 1, 0)));
    end

    // Random legal traffic with threshold-edge means
    while (wr_row_m < 8) begin
      bit gv, mv;
      int cr, cc, g;
      gv = ($urandom_range(3, 0) != 0);
      g  = pick_pix();
      mv = ($urandom_range(1, 0) == 1);
      cr = wr_row_m - 1 - int'($urandom_range(5, 0));
      if (cr < 0) cr = 0;
      cc = int'($urandom_range(W - 1, 0));
      cyc(gv, g, mv, pick_mean(lookup(cr, cc)), cr, cc);
    end
    idle(4);

    // Coordinate recall: pixel (4,4) = 32
    do_reset();
    while (!(wr_row_m == 8 && wr_col_m == 9))
      cyc(1, (wr_row_m * 7 + wr_col_m) & 255, 0, 0, 0, 0);
    cyc(0, 0, 1, 36, 4, 4);
    cyc(0, 0, 1, 37, 4, 4);

    // Overrun: stale, then future request; flag must stick
    while (wr_row_m < 13)
      cyc(1, (wr_row_m * 7 + wr_col_m) & 255, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 4, 0);
    idle(1);
    cyc(0, 0, 1, 0, 20, 0);
    cyc(0, 0, 1, 200, 12, 5);
    idle(4);

    // Reset one cycle after an in-flight request
    cyc(0, 0, 1, 50, 12, 6);
    do_reset();

    // Post-reset writes start at (0,0); offset edge cases
    cyc(1, 90, 0, 0, 0, 0);
    cyc(1, 91, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 255, 0, 0, 0, 0);
    cyc(0, 0, 1, 95, 0, 0);
    cyc(0, 0, 1, 94, 0, 0);
    cyc(0, 0, 1, 95, 0, 1);
    cyc(0, 0, 1, 0, 0, 2);
    cyc(0, 0, 1, 255, 0, 3);
    idle(6);
    check("queue_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
